// File: rtl/commu_push_pkt_if.sv
// commu_push_pkt_if: push control, frame-buffer read and transmitter handshake of commu_push_pkt.
interface commu_push_pkt_if #(parameter int DW_TX = 16);
    logic             fire_push;
    logic             done_push;
    logic             buf_rd;
    logic [7:0]       buf_q;
    logic             buf_frm;
    logic             fire_tx;
    logic             done_tx;
    logic [DW_TX-1:0] data_tx;
    modport master (input fire_push, buf_q, done_tx, output done_push, buf_rd, buf_frm, fire_tx, data_tx);
    modport slave (output fire_push, buf_q, done_tx, input done_push, buf_rd, buf_frm, fire_tx, data_tx);
endinterface

// File: rtl/commu_push_pkt.sv
// commu_push_pkt: reads an NBYTE frame, packs it MSB-first into DW_TX words and sends them word by word.
// Defining COMMU_PUSH_CHKSUM_EN appends a trailer word holding the modulo-2^DW_TX sum of the data words.
module commu_push_pkt #(
    parameter int DW_TX = 16,
    parameter int NBYTE = 32
) (
    input logic clk_sys,
    input logic rst_n,
    commu_push_pkt_if.master bus
);
    localparam int BPW   = DW_TX / 8;
    localparam int NWORD = (NBYTE + BPW - 1) / BPW;
    localparam int BW    = $clog2(NBYTE + 1);
    localparam int WW    = $clog2(NWORD + 2);
    localparam int KW    = $clog2(BPW + 1);

`ifdef COMMU_PUSH_CHKSUM_EN
    typedef enum logic [2:0] {IDLE, RD, CAP, TX, WT, CHK, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD, CAP, TX, WT, DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [BW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [WW-1:0]    word_cnt_q, word_cnt_d;
    logic [KW-1:0]    rd_cnt_q, rd_cnt_d;
    logic [KW-1:0]    cap_cnt_q, cap_cnt_d;
    logic [DW_TX-1:0] sr_q, sr_d;
    logic [DW_TX-1:0] data_tx_q, data_tx_d;
    logic             rd_dly_q, rd_dly_d;
    logic             buf_rd_q, buf_rd_d;
    logic             buf_frm_q, buf_frm_d;
    logic             fire_tx_q, fire_tx_d;
    logic             done_push_q, done_push_d;
`ifdef COMMU_PUSH_CHKSUM_EN
    logic [DW_TX-1:0] sum_q, sum_d;
`endif

    logic last_rd;
    assign last_rd = (rd_cnt_q == KW'(BPW - 1)) || (byte_cnt_q == BW'(NBYTE - 1));

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        cap_cnt_d  = cap_cnt_q;
        sr_d       = sr_q;
        data_tx_d  = data_tx_q;
`ifdef COMMU_PUSH_CHKSUM_EN
        sum_d      = sum_q;
`endif
        // buf_q carries the byte read on the previous cycle
        if (rd_dly_q) begin
            sr_d      = sr_q | (DW_TX'(bus.buf_q) << (8 * (BPW - 1 - int'(cap_cnt_q))));
            cap_cnt_d = cap_cnt_q + KW'(1);
        end
        case (state_q)
            IDLE: if (bus.fire_push) begin
                state_d    = RD;
                byte_cnt_d = '0;
                word_cnt_d = '0;
`ifdef COMMU_PUSH_CHKSUM_EN
                sum_d      = '0;
`endif
            end
            RD: begin
                rd_cnt_d   = rd_cnt_q + KW'(1);
                byte_cnt_d = byte_cnt_q + BW'(1);
                state_d    = last_rd ? CAP : RD;
            end
            CAP: begin
                state_d   = TX;
                data_tx_d = sr_d;
`ifdef COMMU_PUSH_CHKSUM_EN
                sum_d     = sum_q + sr_d;
`endif
            end
            TX: state_d = WT;
            WT: if (bus.done_tx) begin
                word_cnt_d = word_cnt_q + WW'(1);
`ifdef COMMU_PUSH_CHKSUM_EN
                state_d = (word_cnt_q == WW'(NWORD)) ? DONE :
                          (word_cnt_q == WW'(NWORD - 1)) ? CHK : RD;
`else
                state_d = (word_cnt_q == WW'(NWORD - 1)) ? DONE : RD;
`endif
            end
`ifdef COMMU_PUSH_CHKSUM_EN
            CHK: begin
                state_d   = TX;
                data_tx_d = sum_q;
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == RD && state_q != RD) begin
            sr_d      = '0;
            rd_cnt_d  = '0;
            cap_cnt_d = '0;
        end
        rd_dly_d    = buf_rd_q;
        buf_rd_d    = state_d == RD;
        buf_frm_d   = state_d != IDLE;
        fire_tx_d   = state_d == TX;
        done_push_d = state_d == DONE;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            cap_cnt_q   <= '0;
            sr_q        <= '0;
            data_tx_q   <= '0;
            rd_dly_q    <= 1'b0;
            buf_rd_q    <= 1'b0;
            buf_frm_q   <= 1'b0;
            fire_tx_q   <= 1'b0;
            done_push_q <= 1'b0;
`ifdef COMMU_PUSH_CHKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            sr_q        <= sr_d;
            data_tx_q   <= data_tx_d;
            rd_dly_q    <= rd_dly_d;
            buf_rd_q    <= buf_rd_d;
            buf_frm_q   <= buf_frm_d;
            fire_tx_q   <= fire_tx_d;
            done_push_q <= done_push_d;
`ifdef COMMU_PUSH_CHKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign bus.buf_rd    = buf_rd_q;
    assign bus.buf_frm   = buf_frm_q;
    assign bus.fire_tx   = fire_tx_q;
    assign bus.done_push = done_push_q;
    assign bus.data_tx   = data_tx_q;
endmodule

// File: doc/commu_push_pkt.md
# commu_push_pkt

Parametrised frame pusher for the slave-FPGA communication path. On `fire_push`, it does the following:
- reads a fixed-length byte frame from the commu frame buffer;
- packs the bytes MSB-first into `DW_TX`-bit words;
- hands each word to the serial transmitter with a `fire_tx`/`done_tx` handshake;
- pulses `done_push` after the last word.

It generalises the 8→16 bit pusher to any word width and frame length. It adds zero-padding of partial words and an optional checksum trailer word.

## Interface
- `DW_TX`, 16, transmit word width; a multiple of 8, range 8..64.
- `NBYTE`, 32, bytes per frame; range 1..4095.
- `clk_sys`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `fire_push`  in  1  single-cycle start pulse.
- `done_push`  out  1  single-cycle completion pulse.
- `buf_rd`  out  1  byte read strobe; one byte is consumed per high cycle.
- `buf_q`  in  8  buffer read data; valid exactly 1 cycle after `buf_rd`.
- `buf_frm`  out  1  frame lock; high from push start until `done_push`, inclusive.
- `fire_tx`  out  1  single-cycle word-send pulse to the transmitter.
- `done_tx`  in  1  single-cycle pulse from the transmitter: word sent.
- `data_tx`  out  `DW_TX`  word being sent; stable from `fire_tx` until `done_tx`.

## Operation
- Derived constants:
  - BPW = DW_TX/8.
  - NWORD = ceil(NBYTE/BPW).
  - Byte counter width = clog2(NBYTE+1).
  - Word counter width = clog2(NWORD+2).
- States:
  - IDLE: waits for `fire_push`.
  - RD: issues reads for the current word.
  - CAP: captures the final byte of the word.
  - TX: pulses `fire_tx`.
  - WT: waits for `done_tx`.
  - CHK: checksum trailer; only when `COMMU_PUSH_CHKSUM_EN` is defined.
  - DONE: pulses `done_push`.
- Transitions:
  - IDLE→RD on `fire_push`; this also clears the counters and checksum.
  - RD stays for min(BPW, remaining bytes) cycles with `buf_rd`=1, then goes to CAP.
  - CAP→TX.
  - TX→WT.
  - WT→RD on `done_tx` when words remain.
  - WT→CHK or DONE on `done_tx` after the last data word.
  - CHK→TX, sending the checksum word; its `done_tx` leads to DONE.
  - DONE→IDLE.
- Packing:
  - The first byte of a word lands in bits [DW_TX-1:DW_TX-8], and later bytes fill downward.
  - In the last word, unread low bytes are 0x00.
  - The shift register is cleared at each RD entry.
- `buf_frm`=1 in every state except IDLE.
- `fire_push` while not in IDLE is ignored and does not restart the push.
- `done_tx` outside WT is ignored.
- No timeout: the block waits in WT indefinitely.
- Reset mid-operation returns the block to IDLE with all outputs low. The partially read frame is abandoned, and the buffer owner re-arms on `buf_frm` falling.

## Timing
- Reset values: `done_push`=0, `buf_rd`=0, `buf_frm`=0, `fire_tx`=0, `data_tx`=0.
- All outputs are registered.
- If `fire_push` is high at cycle 0, then `buf_frm` and the first `buf_rd` are high at cycle 1.
- For a word whose reads start at cycle t and cover B bytes:
  - `buf_rd` is high for cycles t..t+B-1;
  - bytes are captured at t+1..t+B;
  - `data_tx` is updated at t+B+1, with `fire_tx` high for that one cycle.
- If `done_tx` is high at cycle u, the next word's `buf_rd` rises at u+1.
- `done_push` rises 1 cycle after the final `done_tx`. `buf_frm` falls 1 cycle after `done_push`.
- Minimum frame latency is NWORD·(BPW+3)+1 cycles plus transmitter time.
- `done_tx` coincident with the `fire_tx` cycle is not legal; the transmitter guarantees at least 1 cycle between them.

## Configuration
- Macro: `COMMU_PUSH_CHKSUM_EN`.
- Defined:
  - an accumulator sums all data words, including padding, modulo 2^DW_TX;
  - after the last data word, one extra word carrying this sum is sent through the same TX/WT handshake;
  - the frame is therefore NWORD+1 words.
- Undefined: no CHK state, no accumulator, and the frame is NWORD words.

## Test plan
- DW_TX=16, NBYTE=5, bytes 11 22 33 44 55, macro off:
  - `data_tx` shows 0x1122, 0x3344 and 0x5500 on three `fire_tx` pulses;
  - `buf_rd` totals 5 cycles;
  - one `done_push`.
- Same stimulus, macro on:
  - a fourth word 0x9966 is sent;
  - `done_push` comes 1 cycle after its `done_tx`.
- DW_TX=32, NBYTE=8, bytes 01..08:
  - the words are 0x01020304 and 0x05060708;
  - the exact cycles of `buf_rd`, `fire_tx` and `done_push` match the Timing section.
- Extra `fire_push` pulses during WT, plus a stray `done_tx` in IDLE:
  - output is unchanged;
  - a single `done_push` is produced.
- Assert `rst_n` low during the second word's WT:
  - all outputs are 0 immediately;
  - after release, a new `fire_push` runs a complete correct frame.
- DW_TX=8, NBYTE=1:
  - one `buf_rd`, one `fire_tx` with `data_tx`=`buf_q`, then `done_push`.
